insn_fetch_queue: RTL
=====================

Name: insn_fetch_queue

Overview:
- Registered valid/ready FIFO for 64-bit instruction words; sits directly upstream of the jump-security filter and feeds it one word per cycle.
- Flags each word whose opcode field (bits 31:26) equals 2 (jump) so the filter stage and monitors can see jump traffic.
- Decouples fetch-side bursts from the combinational filter path; all outputs are driven from registers.

Parameters:
- DEPTH, 4, number of 64-bit entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  queue can accept a word this cycle.
- in_data  input  64  instruction word from fetch.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  filter stage consumes the head this cycle.
- out_data  output  64  head word; 0 when empty.
- out_is_jmp  output  1  head word has opcode (bits 31:26) == 2; 0 when empty.
- level  output  $clog2(DEPTH)+1  number of occupied entries.
- jmp_count  output  CNT_W  saturating count of accepted jump words.

Behaviour:
- Reset (rst=1 at a clock edge): read/write pointers, level and jmp_count all go to 0. out_valid=0, out_data=0, out_is_jmp=0. in_ready=0 while rst is high and 1 on the first cycle after release. Storage contents are don't-care; outputs are masked while empty.
- Enqueue when in_valid && in_ready. The word is written at the write pointer, the pointer increments modulo DEPTH, and the is_jmp tag (in_data[31:26]==6'd2) is stored alongside.
- Dequeue when out_valid && out_ready. The read pointer increments modulo DEPTH.
- First-word-fall-through: a word enqueued at edge N is visible on out_data/out_valid after edge N. Minimum latency is one cycle; there is no combinational in-to-out path.
- in_ready = (level != DEPTH). It is computed from registered level only, so a full queue does not accept a word even if a dequeue occurs in the same cycle.
- Enqueue and dequeue in the same cycle (not empty, not full): level is unchanged and both pointers advance.
- Empty with in_valid=1: the word is accepted. out_valid stays 0 that cycle and goes to 1 the next.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from level, not from pointer equality.
- out_data and out_is_jmp are forced to 0 whenever level==0.
- jmp_count increments by 1 on each accepted word with opcode 2 and holds at 2^CNT_W-1 (no wrap).
- in_data is not modified; bits 63:32 pass through untouched.
- rst asserted mid-burst: any in-flight words are discarded and no partial handshake completes on the reset edge.

Optional Feature:
- Macro: SECJMP_NULL_DROP_EN.
- Defined:
  - An accepted word with opcode 2 and target field in_data[25:0]==0 completes its input handshake but is not written; pointers and level are unchanged.
  - Such a word still increments jmp_count.
  - An extra output port drop_count (CNT_W, saturating, reset 0) counts these drops.
  - This removes null-target jumps before the filter sees them.
- Undefined: every accepted word is stored, and the drop_count port does not exist.

Test Plan:
- Reset then idle: after rst high for 2 cycles, then low -> in_ready=1, out_valid=0, out_data=0, level=0, jmp_count=0.
- Single word 64'h0000_0000_0800_0010 (opcode 2, target 0x10) -> out_valid=1 one cycle later, out_data equal to the input, out_is_jmp=1, jmp_count=1.
- Fill to full with out_ready=0, DEPTH=4: words 1..4 -> level=4, in_ready=0. A fifth word is held off. Then out_ready=1 for 4 cycles -> words 1,2,3,4 appear in order and level returns to 0.
- Simultaneous enqueue/dequeue at level=2, streaming 8 words (pointer wrap) -> level stays 2 and output order equals input order.
- jmp_count saturation with CNT_W=4: 17 jump words -> jmp_count=15.
- With SECJMP_NULL_DROP_EN: enqueue 64'h0800_0000 (opcode 2, target 0) then 64'h0000_0001 -> only 64'h0000_0001 emerges, drop_count=1, jmp_count=1, level peaks at 1.

Source files
------------

// File: rtl/insn_fetch_queue.sv
// insn_fetch_queue
//   Registered valid/ready FIFO for 64-bit instruction words. It sits
//   directly upstream of the jump-security filter. Each stored word carries
//   an is_jmp tag (opcode bits 31:26 == 2), and the queue keeps a saturating
//   count of accepted jump words. There is no combinational path from the
//   input to out_data or out_valid; both are driven from storage and level.
//
// Parameters
//   DEPTH  number of 64-bit entries (power of two, >= 2)
//   CNT_W  width of the saturating statistics counters
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    producer presents a word on in_data
//   in_ready    queue accepts a word this cycle (low while rst is high)
//   in_data     instruction word from fetch
//   out_valid   head entry is valid
//   out_ready   filter consumes the head this cycle
//   out_data    head word, 0 when empty
//   out_is_jmp  head word is a jump, 0 when empty
//   level       number of occupied entries
//   jmp_count   saturating count of accepted jump words
//   drop_count  (only with SECJMP_NULL_DROP_EN) saturating count of dropped
//               null-target jumps
//
// Optional build macro: SECJMP_NULL_DROP_EN
//   When defined, an accepted jump whose target field in_data[25:0] is zero
//   completes its handshake but is not stored. It still counts in jmp_count
//   and also counts in drop_count.

module insn_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic                     out_is_jmp,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         jmp_count
`ifdef SECJMP_NULL_DROP_EN
  ,
  output logic [CNT_W-1:0]         drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [63:0]      mem [DEPTH];
  logic [DEPTH-1:0] tag;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] jmp_q;

  logic is_jmp_in;
  logic push;
  logic pop;
  logic wr;

  assign is_jmp_in = (in_data[31:26] == 6'd2);

  // in_ready looks only at the registered level, so a full queue refuses a
  // word even when the head is consumed in the same cycle. Gating with rst
  // keeps any handshake from completing on a reset edge.
  assign in_ready  = !rst && (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef SECJMP_NULL_DROP_EN
  logic             null_jmp;
  logic [CNT_W-1:0] drop_q;

  assign null_jmp = is_jmp_in && (in_data[25:0] == 26'd0);
  assign wr       = push && !null_jmp;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (push && null_jmp && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign drop_count = drop_q;
`else
  assign wr = push;
`endif

  // Storage is not reset; the outputs below are masked while empty.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= in_data;
      tag[wptr] <= is_jmp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jmp_q <= '0;
    end else if (push && is_jmp_in && (jmp_q != '1)) begin
      jmp_q <= jmp_q + CNT_W'(1);
    end
  end

  assign out_data   = out_valid ? mem[rptr] : 64'd0;
  assign out_is_jmp = out_valid && tag[rptr];
  assign level      = level_q;
  assign jmp_count  = jmp_q;

endmodule
